serial_tx_arbiter: RTL



---
 rtl/serial_port_pkg.sv | 13 +
 rtl/rr_select.sv | 26 ++
 rtl/serial_tx_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/serial_port_pkg.sv
// Shared definitions for the serial-port datapath: arbiter state encoding
// and default lock-hold timeout.
package serial_port_pkg;

    typedef enum logic [1:0] {
        ARB  = 2'b00,
        XFER = 2'b01,
        HOLD = 2'b10
    } state_e;

    localparam int HOLD_TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first asserted request at or above rr_ptr,
// wrapping modulo N.
module rr_select #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_valid
);

    int idx;

    // Scan from the farthest candidate back to rr_ptr so the nearest one wins.
    always_comb begin
        winner    = '0;
        any_valid = |req;
        idx       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx    = (int'(rr_ptr) + k) % N;
            winner = req[idx] ? IDX_W'(idx) : winner;
        end
    end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one byte transmitter between NUM_REQ requesters,
// with per-message locking and a HOLD-state inactivity timeout.
module serial_tx_arbiter
    import serial_port_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int HOLD_TIMEOUT = HOLD_TIMEOUT_DEFAULT,
    parameter int ID_W         = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [ID_W-1:0]      grant_id,
    output logic                 locked,
    output logic                 err_timeout
);

    localparam int                TIMER_W    = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(HOLD_TIMEOUT - 1);
    localparam logic [ID_W-1:0]    LAST_ID    = ID_W'(NUM_REQ - 1);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               last_q, last_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               err_timeout_q, err_timeout_d;

    logic [ID_W-1:0]    winner_s;
    logic               any_valid_s;
    logic [ID_W-1:0]    src_id_s;
    logic               grant_en_s;
    logic [NUM_REQ-1:0] ready_s;
    logic [7:0]         sel_data_s;
    logic               sel_last_s;
    logic               xfer_s;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == LAST_ID) ? '0 : id + ID_W'(1);
    endfunction

    rr_select #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_rr_select (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .winner    (winner_s),
        .any_valid (any_valid_s)
    );

    // Grant source and byte mux: the locked owner in HOLD, the fresh winner in ARB.
    always_comb begin
        src_id_s   = (state_q == HOLD) ? grant_id_q : winner_s;
        grant_en_s = !rst && ((state_q == ARB && any_valid_s) || state_q == HOLD);
        ready_s    = '0;
        sel_data_s = 8'h00;
        sel_last_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ready_s[i] = grant_en_s && (ID_W'(i) == src_id_s);
            sel_data_s = sel_data_s | ((ID_W'(i) == src_id_s) ? req_data[8*i +: 8] : 8'h00);
            sel_last_s = sel_last_s | ((ID_W'(i) == src_id_s) ? req_last[i] : 1'b0);
        end
        xfer_s = |(req_valid & ready_s);
    end

    // Next-state logic for the arbitration / transfer / hold sequence.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        tx_valid_d    = tx_valid_q;
        tx_data_d     = tx_data_q;
        last_d        = last_q;
        timer_d       = timer_q;
        err_timeout_d = 1'b0;
        case (state_q)
            ARB, HOLD: begin
                if (xfer_s) begin
                    tx_data_d  = sel_data_s;
                    last_d     = sel_last_s;
                    grant_id_d = src_id_s;
                    tx_valid_d = 1'b1;
                    state_d    = XFER;
                end else if (state_q == HOLD && timer_q == TIMER_LAST) begin
                    err_timeout_d = 1'b1;
                    rr_ptr_d      = next_id(grant_id_q);
                    state_d       = ARB;
                end else if (state_q == HOLD) begin
                    timer_d = timer_q + TIMER_W'(1);
                end else begin
                    state_d = ARB;
                end
            end
            XFER: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (last_q) begin
                        rr_ptr_d = next_id(grant_id_q);
                        state_d  = ARB;
                    end else begin
                        timer_d = '0;
                        state_d = HOLD;
                    end
                end else begin
                    tx_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    // State and output registers; reset drops tx_valid without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ARB;
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            last_q        <= 1'b0;
            timer_q       <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_id_q    <= grant_id_d;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
            last_q        <= last_d;
            timer_q       <= timer_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign req_ready   = ready_s;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign grant_id    = grant_id_q;
    assign locked      = (state_q != ARB);
    assign err_timeout = err_timeout_q;

endmodule
